// File: rtl/round_delay_timer.sv
// rtl/round_delay_timer.sv - inter-round delay timer with sticky final-finish flag
module round_delay_timer #(
  parameter int N_PLAYERS    = 2,
  parameter int CNT_W        = 28,
  parameter int ROUND_CYCLES = 36000000,
  parameter int FINAL_CYCLES = 60000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_PLAYERS-1:0] start,
  input  logic                 is_final,
  output logic                 is_wait,
  output logic                 is_final_finish,
  output logic                 done_pulse,
  output logic [CNT_W-1:0]     cnt_out
);

  localparam logic [CNT_W-1:0] ROUND_TGT = CNT_W'(ROUND_CYCLES);
  localparam logic [CNT_W-1:0] FINAL_TGT = CNT_W'(FINAL_CYCLES);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNT    = 2'd1,
    FINISHED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic             final_q, final_d;
  logic             held_prev_q;
  logic             wait_q, wait_d;
  logic             ff_q, ff_d;
  logic             done_q, done_d;

  logic any_held;
  logic trigger;

  // A trigger is the release of the last held button: some button was held
  // last cycle and none is held now.
  assign any_held = |start;
  assign trigger  = held_prev_q & ~any_held;

  // Next-state logic: trigger from IDLE starts a delay, COUNT runs to the
  // latched target, FINISHED parks until reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    final_d = final_q;
    wait_d  = wait_q;
    ff_d    = ff_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        wait_d = 1'b1;
        if (trigger) begin
          state_d = COUNT;
          cnt_d   = '0;
          wait_d  = 1'b0;
          tgt_d   = is_final ? FINAL_TGT : ROUND_TGT;
          final_d = is_final;
        end
      end
      COUNT: begin
        if (cnt_q == tgt_q - ONE) begin
          cnt_d  = '0;
          done_d = 1'b1;
          wait_d = 1'b1;
          if (final_q) begin
            ff_d    = 1'b1;
            state_d = FINISHED;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      FINISHED: begin
        wait_d = 1'b1;
        ff_d   = 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        wait_d  = 1'b1;
      end
    endcase
  end

  // State and output registers; reset overrides everything, and the
  // previous-held register tracks the buttons in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tgt_q       <= ROUND_TGT;
      final_q     <= 1'b0;
      held_prev_q <= 1'b0;
      wait_q      <= 1'b1;
      ff_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tgt_q       <= tgt_d;
      final_q     <= final_d;
      held_prev_q <= any_held;
      wait_q      <= wait_d;
      ff_q        <= ff_d;
      done_q      <= done_d;
    end
  end

  assign is_wait         = wait_q;
  assign is_final_finish = ff_q;
  assign done_pulse      = done_q;
  assign cnt_out         = cnt_q;

endmodule
